// File: rtl/mfcc_delta_pkg.sv
// Shared constants, types and helpers for the MFCC delta stage.
package mfcc_pkg;

  localparam int MFCC_NCOEF = 12;  // cepstral coefficients per frame
  localparam int MFCC_DW    = 14;  // signed coefficient width (DCT output width)
  localparam int MFCC_IW    = 4;   // coefficient index width

  typedef logic signed [MFCC_DW-1:0] coef_t;

  // WARM0/WARM1 count good frames collected since the history was last invalidated.
  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } delta_state_t;

  // Advance a history slot pointer 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] mod3_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/mfcc_hist_regfile.sv
// Three-frame coefficient history: one write port, two combinational read ports.
module mfcc_hist_regfile
  import mfcc_pkg::*;
#(
  parameter int NCOEF = MFCC_NCOEF,
  parameter int DW    = MFCC_DW,
  parameter int IW    = MFCC_IW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    wr_slot,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    rd_slot_a,
  input  logic [IW-1:0] rd_idx_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [1:0]    rd_slot_b,
  input  logic [IW-1:0] rd_idx_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] mem [3][NCOEF];

  // Store one coefficient into the slot currently being filled.
  // NOTE: the array has no reset; the control FSM never reads a slot before a
  // full good frame has been written into it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_slot][wr_idx] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_slot_a][rd_idx_a];
  assign rd_data_b = mem[rd_slot_b][rd_idx_b];

endmodule

// File: rtl/mfcc_delta.sv
// MFCC delta stage: buffers three frames and emits static + first-order delta
// for the centred frame, one frame behind the input stream.
module mfcc_delta
  import mfcc_pkg::*;
#(
  parameter int NCOEF = MFCC_NCOEF,
  parameter int DW    = MFCC_DW,
  parameter int IW    = MFCC_IW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] coef_in,
  input  logic                 coef_valid,
  input  logic                 frame_done,
  output logic                 out_valid,
  output logic [IW-1:0]        out_idx,
  output logic signed [DW-1:0] out_static,
  output logic signed [DW-1:0] out_delta,
  output logic                 out_frame_done,
  output logic                 frame_err,
  output logic                 warm
);

  // Count is one bit wider than the index so it can hold NCOEF itself.
  localparam logic [IW:0] NCOEF_C = (IW + 1)'(NCOEF);

  delta_state_t state, state_next;
  logic [1:0]   wr_slot;
  logic [1:0]   p1_slot;   // holds c_{t-1}
  logic [1:0]   p2_slot;   // holds c_{t-2}
  logic [IW:0]  count;
  logic [IW:0]  count_fin;
  logic         over;      // frame has already seen a coefficient past NCOEF
  logic         acc;
  logic         ovf_now;
  logic         frame_good;
  logic [DW-1:0] rd_p1;
  logic [DW-1:0] rd_p2;
  logic signed [DW:0] diff;
  logic signed [DW:0] half;

  assign p2_slot = mod3_inc(wr_slot);
  assign p1_slot = mod3_inc(p2_slot);

  assign acc        = coef_valid && (count < NCOEF_C);
  assign ovf_now    = coef_valid && !acc;
  assign count_fin  = acc ? count + (IW + 1)'(1) : count;
  assign frame_good = (count_fin == NCOEF_C) && !over && !ovf_now;

  // DW+1 bit difference cannot overflow; the floor shift brings it back into DW bits.
  assign diff = $signed({coef_in[DW-1], coef_in}) - $signed({rd_p2[DW-1], rd_p2});
  assign half = diff >>> 1;

  assign warm = (state == RUN);

  mfcc_hist_regfile #(
    .NCOEF (NCOEF),
    .DW    (DW),
    .IW    (IW)
  ) u_hist (
    .clk       (clk),
    .we        (acc),
    .wr_slot   (wr_slot),
    .wr_idx    (count[IW-1:0]),
    .wr_data   (coef_in),
    .rd_slot_a (p1_slot),
    .rd_idx_a  (count[IW-1:0]),
    .rd_data_a (rd_p1),
    .rd_slot_b (p2_slot),
    .rd_idx_b  (count[IW-1:0]),
    .rd_data_b (rd_p2)
  );

  // Warm-up progression taken on every good frame; a bad frame restarts it.
  // NOTE: every branch assigns state_next after the default, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (frame_done) begin
      if (!frame_good) begin
        state_next = WARM0;
      end else begin
        unique case (state)
          WARM0:   state_next = WARM1;
          WARM1:   state_next = RUN;
          default: state_next = RUN;
        endcase
      end
    end
  end

  // Frame bookkeeping: coefficient count, overflow flag, write slot and FSM state.
  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WARM0;
      wr_slot <= 2'd0;
      count   <= '0;
      over    <= 1'b0;
    end else begin
      state <= state_next;
      if (frame_done) begin
        count <= '0;
        over  <= 1'b0;
        if (frame_good) begin
          wr_slot <= mod3_inc(wr_slot);
        end
      end else begin
        count <= count_fin;
        over  <= over | ovf_now;
      end
    end
  end

  // Registered outputs, one cycle behind the coefficient or frame_done that caused them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_idx        <= '0;
      out_static     <= '0;
      out_delta      <= '0;
      out_frame_done <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      out_valid      <= acc && (state == RUN);
      out_frame_done <= frame_done && frame_good && (state == RUN);
      frame_err      <= frame_done && !frame_good;
      if (acc && (state == RUN)) begin
        out_idx    <= count[IW-1:0];
        out_static <= rd_p1;
        out_delta  <= half[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mfcc_delta.sv
// Self-checking bench for mfcc_delta: directed scenarios with literal pins,
// then randomized frames, all compared each cycle against a frame-level model.
module tb_mfcc_delta;
  import mfcc_pkg::*;

  localparam int NC = MFCC_NCOEF;
  localparam int DW = MFCC_DW;
  localparam int IW = MFCC_IW;

  typedef int frame_t [NC+1];

  typedef struct {
    bit valid;
    int idx;
    int stat;
    int delta;
    bit ofd;
    bit err;
    bit warm;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] coef_in;
  logic                 coef_valid;
  logic                 frame_done;
  logic                 out_valid;
  logic [IW-1:0]        out_idx;
  logic signed [DW-1:0] out_static;
  logic signed [DW-1:0] out_delta;
  logic                 out_frame_done;
  logic                 frame_err;
  logic                 warm;

  always #5 clk = ~clk;

  mfcc_delta dut (
    .clk            (clk),
    .rst            (rst),
    .coef_in        (coef_in),
    .coef_valid     (coef_valid),
    .frame_done     (frame_done),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .out_static     (out_static),
    .out_delta      (out_delta),
    .out_frame_done (out_frame_done),
    .frame_err      (frame_err),
    .warm           (warm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  int   f1 [NC];        // last good frame (t-1)
  int   f2 [NC];        // good frame before that (t-2)
  int   cur [NC];       // frame being received
  int   good_run = 0;   // consecutive good frames held, saturating at 2
  int   cnt = 0;
  bit   over = 0;
  exp_t pend, expv;

  function automatic int floor_half(input int d);
    int q;
    q = d / 2;
    if (d < 0 && (d % 2) != 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_step(input bit v, input int c, input bit fd, input bit r);
    pend.valid = 0;
    pend.ofd   = 0;
    pend.err   = 0;
    if (r) begin
      good_run   = 0;
      cnt        = 0;
      over       = 0;
      pend.idx   = 0;
      pend.stat  = 0;
      pend.delta = 0;
      pend.warm  = 0;
      return;
    end
    if (v) begin
      if (cnt < NC) begin
        cur[cnt] = c;
        if (good_run >= 2) begin
          pend.valid = 1;
          pend.idx   = cnt;
          pend.stat  = f1[cnt];
          pend.delta = floor_half(c - f2[cnt]);
        end
        cnt++;
      end else begin
        over = 1;
      end
    end
    if (fd) begin
      if (cnt == NC && !over) begin
        if (good_run >= 2) pend.ofd = 1;
        f2 = f1;
        f1 = cur;
        if (good_run < 2) good_run++;
      end else begin
        pend.err = 1;
        good_run = 0;
      end
      cnt  = 0;
      over = 0;
    end
    pend.warm = (good_run >= 2);
  endfunction

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  int seen_valid = 0;
  int seen_idx, seen_static, seen_delta;

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, expv.valid);
      if (expv.valid) begin
        check("out_idx", out_idx, expv.idx);
        check("out_static", out_static, expv.stat);
        check("out_delta", out_delta, expv.delta);
      end
      check("out_frame_done", out_frame_done, expv.ofd);
      check("frame_err", frame_err, expv.err);
      check("warm", warm, expv.warm);
      if (out_valid) begin
        seen_valid++;
        seen_idx    = out_idx;
        seen_static = out_static;
        seen_delta  = out_delta;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input int c, input bit fd, input bit r);
    rst        = r;
    coef_valid = v;
    coef_in    = DW'(c);
    frame_done = fd;
    model_step(v, c, fd, r);
    @(posedge clk);
    expv = pend;
    #2;
  endtask

  function automatic frame_t const_frame(input int v);
    frame_t f;
    for (int i = 0; i <= NC; i++) f[i] = v;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i <= NC; i++) f[i] = int'($urandom_range(0, 16383)) - 8192;
    return f;
  endfunction

  task automatic send_frame(input frame_t vals, input int n, input bit merge);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
      step(1, vals[i], merge && (i == n - 1), 0);
    end
    if (!merge) step(0, 0, 1, 0);
  endtask

  // Sends a good frame of constant value and returns how many outputs it produced.
  task automatic good_frame(input int v, output int produced);
    int base;
    base = seen_valid;
    send_frame(const_frame(v), NC, 0);
    produced = seen_valid - base;
  endtask

  int produced;
  int base;

  initial begin
    chk_en = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_static", out_static, 0);
    check("reset out_delta", out_delta, 0);
    check("reset warm", warm, 0);
    step(0, 0, 0, 0);

    // Warm-up: 10, 20, then 40 produces output.
    good_frame(10, produced);
    check("warmup f1 outputs", produced, 0);
    check("warmup f1 warm", warm, 0);
    good_frame(20, produced);
    check("warmup f2 outputs", produced, 0);
    good_frame(40, produced);
    check("warmup f3 outputs", produced, 12);
    check("warmup f3 last idx", seen_idx, 11);
    check("warmup f3 static", seen_static, 20);
    check("warmup f3 delta", seen_delta, 15);
    check("warmup f3 out_frame_done", out_frame_done, 1);
    check("warmup f3 warm", warm, 1);

    // Extremes and floor behaviour.
    good_frame(-8192, produced);
    good_frame(0, produced);
    good_frame(8191, produced);
    check("max positive delta", seen_delta, 8191);
    good_frame(0, produced);
    good_frame(-8192, produced);
    check("max negative delta", seen_delta, -8192);
    good_frame(5, produced);
    good_frame(0, produced);
    good_frame(2, produced);
    check("odd diff floor delta", seen_delta, -2);
    check("odd diff static", seen_static, 0);

    // Short frame.
    base = seen_valid;
    send_frame(const_frame(7), 11, 0);
    check("short outputs", seen_valid - base, 11);
    check("short frame_err", frame_err, 1);
    check("short out_frame_done", out_frame_done, 0);
    check("short warm", warm, 0);
    good_frame(1, produced);
    check("after short f1", produced, 0);
    good_frame(2, produced);
    check("after short f2", produced, 0);
    good_frame(3, produced);
    check("after short f3", produced, 12);

    // Long frame: 13th coefficient ignored.
    base = seen_valid;
    send_frame(const_frame(-100), 13, 0);
    check("long outputs", seen_valid - base, 12);
    check("long last idx", seen_idx, 11);
    check("long frame_err", frame_err, 1);
    check("long warm", warm, 0);
    good_frame(4, produced);
    good_frame(6, produced);
    good_frame(9, produced);
    check("after long f3", produced, 12);

    // frame_done together with the last coefficient.
    send_frame(const_frame(11), NC, 1);
    check("merged out_valid", out_valid, 1);
    check("merged out_idx", out_idx, 11);
    check("merged out_frame_done", out_frame_done, 1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) step(1, 50 + i, 0, 0);
    step(1, 55, 0, 1);
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out_static", out_static, 0);
    check("mid reset out_delta", out_delta, 0);
    check("mid reset warm", warm, 0);
    step(0, 0, 0, 0);
    good_frame(12, produced);
    check("after reset f1", produced, 0);
    good_frame(13, produced);
    check("after reset f2", produced, 0);
    good_frame(14, produced);
    check("after reset f3", produced, 12);

    // Randomized frames.
    for (int f = 0; f < 80; f++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? NC - 1 : (r == 1) ? NC + 1 : NC;
      if ($urandom_range(0, 29) == 0) begin
        step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
      end
      send_frame(rand_frame(), n, bit'($urandom_range(0, 1)));
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
